es_mul_sched: RTL
=================

ES_MUL_SCHED -- requirements
Module: es_mul_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 5, operand width in bits; legal 2..8.
REQ-002 SHALL have parameter NUM_INPUTS, default 2, operand count; legal 2..4.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand set offered.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port op_data  input  NUM_INPUTS*DATA_WIDTH  operands; op[i] = bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port abort  input  1  synchronous cancel of current job.
REQ-009 SHALL have port busy  output  1  high in RUN.
REQ-010 SHALL have port sn_out  output  NUM_INPUTS  current unary stream bit per operand.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer takes result.
REQ-013 SHALL have port result  output  NUM_INPUTS*DATA_WIDTH  product of operands.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; in_ready = (state==IDLE); busy = (state==RUN); out_valid = (state==DONE).
REQ-015 SHALL accept a job on a rising edge with in_valid & in_ready, latching all op[i] into internal registers; op_data ignored at all other times.
REQ-016 On accept, if any op[i]==0: SHALL go IDLE->DONE with result 0 (out_valid one cycle after accept, no RUN cycles).
REQ-017 On accept with all op[i]!=0: SHALL go IDLE->RUN, clear accumulator and counters c[0..NUM_INPUTS-1] (each DATA_WIDTH bits).
REQ-018 In RUN, c[0] SHALL increment every cycle; c[i] (i>0) SHALL increment only when c[0..i-1] are all at 2^DATA_WIDTH-1 (nested enable, no derived clocks); counters wrap to 0.
REQ-019 In RUN, sn_out[i] SHALL equal (c[i] < op[i]); sn_out SHALL be 0 in IDLE and DONE.
REQ-020 Each RUN cycle with c[NUM_INPUTS-1] < op[NUM_INPUTS-1]: accumulator SHALL add 1 iff all sn_out bits are 1.
REQ-021 First RUN cycle with c[NUM_INPUTS-1] >= op[NUM_INPUTS-1] (early termination, last stream exhausted): SHALL not accumulate and SHALL go RUN->DONE, result <= accumulator.
REQ-022 RUN length SHALL be exactly op[NUM_INPUTS-1]*2^((NUM_INPUTS-1)*DATA_WIDTH)+1 cycles; result SHALL equal the exact integer product of all op[i].
REQ-023 Accumulator and result SHALL be NUM_INPUTS*DATA_WIDTH bits; no overflow possible since product < 2^(NUM_INPUTS*DATA_WIDTH).
REQ-024 In DONE, result SHALL be held stable; on a rising edge with out_ready high SHALL go DONE->IDLE; no new job accepted in the same cycle.
REQ-025 abort high in RUN or DONE SHALL force IDLE on the next edge with out_valid low and no result delivered; abort in IDLE SHALL be ignored; abort takes priority over out_ready and termination.
REQ-026 result SHALL retain its last value in IDLE and RUN until the next DONE entry.

Reset
REQ-027 rst low SHALL asynchronously force state IDLE, counters, accumulator, latched operands and result to 0; in_ready=1, busy=0, out_valid=0, sn_out=0.
REQ-028 Reset asserted mid-RUN or in DONE SHALL discard the job; first accept is possible on the first edge after rst deasserts.

Verification
REQ-029 W=3,N=2, op=(5,3), out_ready=1 -> busy for 25 cycles, out_valid one cycle, result=15.
REQ-030 W=3,N=2, op=(0,7) and op=(7,0) -> out_valid the cycle after accept, result=0, busy never asserts.
REQ-031 W=3,N=2, op=(7,7), out_ready held low 10 cycles -> busy 57 cycles, result=49 stable while out_valid, in_ready low until out_ready.
REQ-032 W=2,N=3, op=(3,2,1) -> busy 17 cycles, result=6; sn_out[2] low only on final RUN cycle.
REQ-033 abort pulse in RUN cycle 4, then rst low mid-RUN of next job -> IDLE without out_valid each time; follow-up op=(2,2), W=3 gives result=4.
REQ-034 Back-to-back jobs with in_valid held high -> second accept only after DONE->IDLE, results match products in order.

Source files
------------

// File: rtl/es_mul_sched.sv
// Stochastic-style multiplier scheduler: counts unary stream coincidences of nested
// operand counters to form the exact product of NUM_INPUTS operands.
module es_mul_sched #(
    parameter int DATA_WIDTH = 5,
    parameter int NUM_INPUTS = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] op_data,
    input  logic                             abort,
    output logic                             busy,
    output logic [NUM_INPUTS-1:0]            sn_out,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] result
);

    localparam int RW = NUM_INPUTS * DATA_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] op_q [NUM_INPUTS];
    logic [DATA_WIDTH-1:0] cnt  [NUM_INPUTS];
    logic [RW-1:0]         acc;
    logic [NUM_INPUTS-1:0] cnt_en;
    logic                  any_zero;
    logic                  last_done;

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state == S_RUN);
    assign out_valid = (state == S_DONE);

    // Counter i advances only when every lower counter is about to wrap.
    always_comb begin
        any_zero  = 1'b0;
        cnt_en    = '0;
        sn_out    = '0;
        cnt_en[0] = 1'b1;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (op_data[i*DATA_WIDTH +: DATA_WIDTH] == '0)
                any_zero = 1'b1;
            sn_out[i] = (state == S_RUN) && (cnt[i] < op_q[i]);
        end
        for (int i = 1; i < NUM_INPUTS; i++)
            cnt_en[i] = cnt_en[i-1] && (cnt[i-1] == '1);
        last_done = (cnt[NUM_INPUTS-1] >= op_q[NUM_INPUTS-1]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            acc    <= '0;
            result <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                op_q[i] <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < NUM_INPUTS; i++)
                            op_q[i] <= op_data[i*DATA_WIDTH +: DATA_WIDTH];
                        if (any_zero) begin
                            result <= '0;
                            state  <= S_DONE;
                        end else begin
                            acc <= '0;
                            for (int i = 0; i < NUM_INPUTS; i++)
                                cnt[i] <= '0;
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (last_done) begin
                        // Last stream exhausted: no further coincidences can occur.
                        result <= acc;
                        state  <= S_DONE;
                    end else begin
                        if (&sn_out)
                            acc <= acc + RW'(1);
                        for (int i = 0; i < NUM_INPUTS; i++)
                            if (cnt_en[i])
                                cnt[i] <= cnt[i] + DATA_WIDTH'(1);
                    end
                end
                S_DONE: begin
                    if (abort || out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
